// File: rtl/icache_fetch_responder_pkg.sv
// Shared constants and state encoding for the instruction-cache fetch responder.
// Geometry: 1 KiB address space, 8 direct-mapped lines of 16-byte blocks.
package icache_fetch_responder_pkg;

    localparam int ADDR_BITS   = 10;
    localparam int INDEX_BITS  = 3;
    localparam int OFFSET_BITS = 4;
    localparam int TAG_BITS    = ADDR_BITS - INDEX_BITS - OFFSET_BITS;
    localparam int BLK_AD_BITS = ADDR_BITS - OFFSET_BITS;
    localparam int BLOCK_BITS  = 128;
    localparam int WORD_BITS   = 32;
    localparam int LINES       = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_UPDATE = 2'd2
    } state_e;

endpackage

// File: rtl/icache_fetch_responder_array.sv
// Valid/tag/data storage for the instruction cache.
// Valids clear asynchronously; tags and data are never cleared.
module icache_array
    import icache_fetch_responder_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [BLOCK_BITS-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [BLOCK_BITS-1:0] wr_data
);

    logic [LINES-1:0]                 valid_q, valid_d;
    logic [LINES-1:0][TAG_BITS-1:0]   tag_q, tag_d;
    logic [LINES-1:0][BLOCK_BITS-1:0] data_q, data_d;

    // Single write port: a fill overwrites one whole line.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_en) begin
            valid_d[wr_index] = 1'b1;
            tag_d[wr_index]   = wr_tag;
            data_d[wr_index]  = wr_data;
        end
    end

    // Valid bits are the only state that reset clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) valid_q <= '0;
        else     valid_q <= valid_d;
    end

    // Tag and data storage, no reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    // Combinational read port.
    always_comb begin
        rd_valid = valid_q[rd_index];
        rd_tag   = tag_q[rd_index];
        rd_data  = data_q[rd_index];
    end

endmodule

// File: rtl/icache_fetch_responder.sv
// Fetch-side responder: serves PC lookups from a direct-mapped I-cache
// and stalls the CPU while a missing block is read from memory.
module icache_fetch_responder
    import icache_fetch_responder_pkg::*;
(
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [31:0]            PC,
    output logic [31:0]            INSTRUCTION,
    output logic                   BUSYWAIT,
    output logic                   MEM_READ,
    output logic [BLK_AD_BITS-1:0] MEM_ADDRESS,
    input  logic [BLOCK_BITS-1:0]  MEM_READDATA,
    input  logic                   MEM_BUSYWAIT
);

    state_e state_q, state_d;

    logic [TAG_BITS-1:0]    fill_tag_q, fill_tag_d;
    logic [INDEX_BITS-1:0]  fill_idx_q, fill_idx_d;
    logic                   mem_read_q, mem_read_d;
    logic [BLK_AD_BITS-1:0] mem_addr_q, mem_addr_d;

    logic [TAG_BITS-1:0]    pc_tag;
    logic [INDEX_BITS-1:0]  pc_idx;
    logic [1:0]             pc_word;
    logic                   rd_valid;
    logic [TAG_BITS-1:0]    rd_tag;
    logic [BLOCK_BITS-1:0]  rd_data;
    logic                   hit;
    logic                   wr_en;
    logic                   unused_pc;

    assign pc_tag    = PC[ADDR_BITS-1 -: TAG_BITS];
    assign pc_idx    = PC[OFFSET_BITS +: INDEX_BITS];
    assign pc_word   = PC[3:2];
    assign unused_pc = ^{PC[31:ADDR_BITS], PC[1:0]};

    assign hit   = rd_valid && (rd_tag == pc_tag);
    assign wr_en = (state_q == S_FETCH) && !MEM_BUSYWAIT && !RESET;

    icache_array u_array (
        .clk      (CLK),
        .rst      (RESET),
        .rd_index (pc_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_index (fill_idx_q),
        .wr_tag   (fill_tag_q),
        .wr_data  (MEM_READDATA)
    );

    // State and fill-request registers; reset abandons any fill in flight.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            fill_tag_q <= '0;
            fill_idx_q <= '0;
            mem_read_q <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            fill_tag_q <= fill_tag_d;
            fill_idx_q <= fill_idx_d;
            mem_read_q <= mem_read_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // Next state: miss latches the line, memory ready completes the fill.
    always_comb begin
        state_d    = state_q;
        fill_tag_d = fill_tag_q;
        fill_idx_d = fill_idx_q;
        mem_read_d = mem_read_q;
        mem_addr_d = mem_addr_q;
        unique case (state_q)
            S_IDLE: begin
                if (!hit) begin
                    state_d    = S_FETCH;
                    fill_tag_d = pc_tag;
                    fill_idx_d = pc_idx;
                    mem_read_d = 1'b1;
                    mem_addr_d = PC[ADDR_BITS-1:OFFSET_BITS];
                end
            end
            S_FETCH: begin
                if (!MEM_BUSYWAIT) begin
                    state_d    = S_UPDATE;
                    mem_read_d = 1'b0;
                end
            end
            S_UPDATE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs: stall unless idle and hitting; word shown whenever line valid.
    always_comb begin
        MEM_READ    = mem_read_q;
        MEM_ADDRESS = mem_addr_q;
        BUSYWAIT    = 1'b0;
        INSTRUCTION = '0;
        if (!RESET) begin
            BUSYWAIT = (state_q != S_IDLE) || !hit;
            if (rd_valid)
                INSTRUCTION = rd_data[{pc_word, 5'b0} +: WORD_BITS];
        end
    end

endmodule
